// File: rtl/vc_pop_arbiter.sv
// Round-robin arbiter draining four VC FIFOs into one downstream FIFO, throttled by almost_full.
// Optional per-channel grant counters are built when ARB_CNT_EN is defined.
module vc_pop_arbiter #(
   parameter int unsigned data_width = 10,
   parameter int unsigned NUM_CH     = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [3:0]            empty_in,
   input  logic [data_width-1:0] data_in0,
   input  logic [data_width-1:0] data_in1,
   input  logic [data_width-1:0] data_in2,
   input  logic [data_width-1:0] data_in3,
   input  logic                  almost_full_out,
   output logic [3:0]            pop,
   output logic                  push_out,
   output logic [data_width-1:0] data_out,
   output logic [1:0]            grant,
`ifdef ARB_CNT_EN
   output logic [31:0]           grant_cnt,
`endif
   output logic                  busy
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACTIVE = 2'd1;
   localparam logic [1:0] STALL  = 2'd2;

   logic [1:0] state, state_nxt;
   logic [1:0] rr_ptr;
   logic [1:0] sel_q;
   logic       pop_q;
   logic       pop_any;
   logic [1:0] pop_idx;
   logic [1:0] idx;
   logic       all_empty;

   assign all_empty = &empty_in;

   // First non-empty channel at or above rr_ptr, modulo 4; gated so reset never pops.
   always_comb begin
      pop_any = 1'b0;
      pop_idx = '0;
      idx     = '0;
      if (state == ACTIVE && enable && !almost_full_out && !reset) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = rr_ptr + 2'(i);
            if (!pop_any && !empty_in[idx]) begin
               pop_any = 1'b1;
               pop_idx = idx;
            end
         end
      end
   end

   assign pop = pop_any ? (4'b0001 << pop_idx) : '0;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:
            if (enable && !all_empty && !almost_full_out) state_nxt = ACTIVE;
         ACTIVE:
            if (almost_full_out)              state_nxt = STALL;
            else if (!enable || all_empty)    state_nxt = IDLE;
         STALL:
            if (!almost_full_out && enable && !all_empty) state_nxt = ACTIVE;
            else                                           state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         rr_ptr <= '0;
         sel_q  <= '0;
         pop_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         pop_q <= pop_any;
         if (pop_any) begin
            rr_ptr <= pop_idx + 2'd1;
            sel_q  <= pop_idx;
         end
      end
   end

   // sel_q only moves on a pop, so grant naturally holds between pushes.
   assign push_out = pop_q;
   assign grant    = sel_q;
   assign busy     = (state == ACTIVE) || (state == STALL);

   always_comb begin
      data_out = '0;
      if (pop_q) begin
         case (sel_q)
            2'd0:    data_out = data_in0;
            2'd1:    data_out = data_in1;
            2'd2:    data_out = data_in2;
            default: data_out = data_in3;
         endcase
      end
   end

`ifdef ARB_CNT_EN
   logic [7:0] cnt [4];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      end else if (push_out) begin
         cnt[grant] <= cnt[grant] + 8'd1;
      end
   end

   assign grant_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Directed bench for vc_pop_arbiter: a small FIFO-bank model feeds the DUT, expected values are hand-computed.
module tb_vc_pop_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [3:0]  empty_in;
   logic [9:0]  data_in0, data_in1, data_in2, data_in3;
   logic        almost_full_out;
   logic [3:0]  pop;
   logic        push_out;
   logic [9:0]  data_out;
   logic [1:0]  grant;
   logic        busy;
`ifdef ARB_CNT_EN
   logic [31:0] grant_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Input FIFO bank: rd owned by the model, wr and off owned by the stimulus.
   logic [15:0] rd [4] = '{default: 16'd0};
   logic [15:0] wr [4] = '{default: 16'd0};
   logic [9:0]  off[4] = '{default: 10'd0};
   logic [9:0]  dreg[4] = '{default: 10'd0};

   always #5 clk = ~clk;

   always_comb
      for (int i = 0; i < 4; i++) empty_in[i] = (rd[i] == wr[i]);

   always @(posedge clk)
      for (int i = 0; i < 4; i++)
         if (pop[i]) begin
            dreg[i] <= off[i] + rd[i][9:0];
            rd[i]   <= rd[i] + 16'd1;
         end

   assign data_in0 = dreg[0];
   assign data_in1 = dreg[1];
   assign data_in2 = dreg[2];
   assign data_in3 = dreg[3];

   vc_pop_arbiter #(.data_width(10), .NUM_CH(4)) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .empty_in(empty_in),
      .data_in0(data_in0),
      .data_in1(data_in1),
      .data_in2(data_in2),
      .data_in3(data_in3),
      .almost_full_out(almost_full_out),
      .pop(pop),
      .push_out(push_out),
      .data_out(data_out),
      .grant(grant),
`ifdef ARB_CNT_EN
      .grant_cnt(grant_cnt),
`endif
      .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int ch, input int n, input logic [9:0] base);
      off[ch] = base - rd[ch][9:0];
      wr[ch]  = rd[ch] + 16'(n);
   endtask

   task automatic drain_all();
      for (int i = 0; i < 4; i++) wr[i] = rd[i];
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   // Checks one cycle's outputs; pop is combinational so inputs must already be set.
   task automatic outs(input string tag, input logic [3:0] e_pop, input logic e_push,
                       input logic [9:0] e_data, input logic [1:0] e_grant);
      chk({tag, "_pop"},   32'(pop),      32'(e_pop));
      chk({tag, "_push"},  32'(push_out), 32'(e_push));
      chk({tag, "_data"},  32'(data_out), 32'(e_data));
      chk({tag, "_grant"}, 32'(grant),    32'(e_grant));
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; almost_full_out = 1'b0;

      // 1: reset with every FIFO non-empty
      @(negedge clk);
      for (int i = 0; i < 4; i++) wr[i] = rd[i] + 16'd1;
      cyc(); outs("t1_rst0", 4'b0000, 1'b0, 10'h000, 2'd0);
      cyc(); outs("t1_rst1", 4'b0000, 1'b0, 10'h000, 2'd0);
      chk("t1_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      cyc(); outs("t1_post", 4'b0000, 1'b0, 10'h000, 2'd0);
      drain_all();

      // 2: ch0 alone holds 090..093
      load(0, 4, 10'h090); enable = 1'b1;
      #1; chk("t2_idle_pop", 32'(pop), 32'd0);
      cyc(); outs("t2_c1", 4'b0001, 1'b0, 10'h000, 2'd0);
      cyc(); outs("t2_c2", 4'b0001, 1'b1, 10'h090, 2'd0);
      cyc(); outs("t2_c3", 4'b0001, 1'b1, 10'h091, 2'd0);
      cyc(); outs("t2_c4", 4'b0001, 1'b1, 10'h092, 2'd0);
      cyc(); outs("t2_c5", 4'b0000, 1'b1, 10'h093, 2'd0);
      chk("t2_busy5", 32'(busy), 32'd1);
      cyc(); outs("t2_c6", 4'b0000, 1'b0, 10'h000, 2'd0);
      chk("t2_idle", 32'(busy), 32'd0);

      // 3: all channels, rr_ptr back to 0 via reset
      reset = 1'b1; enable = 1'b0;
      cyc(); reset = 1'b0;
      for (int i = 0; i < 4; i++) load(i, 2, 10'(i * 256));
      enable = 1'b1;
      cyc(); outs("t3_c1", 4'b0001, 1'b0, 10'h000, 2'd0);
      cyc(); outs("t3_c2", 4'b0010, 1'b1, 10'h000, 2'd0);
      cyc(); outs("t3_c3", 4'b0100, 1'b1, 10'h100, 2'd1);
      cyc(); outs("t3_c4", 4'b1000, 1'b1, 10'h200, 2'd2);
      cyc(); outs("t3_c5", 4'b0001, 1'b1, 10'h300, 2'd3);

      // 4: almost_full rises while ACTIVE
      cyc(); almost_full_out = 1'b1; #1;
      outs("t4_c6", 4'b0000, 1'b1, 10'h001, 2'd0);
      cyc(); outs("t4_c7", 4'b0000, 1'b0, 10'h000, 2'd0);
      chk("t4_stall_busy", 32'(busy), 32'd1);
      cyc(); almost_full_out = 1'b0; #1;
      chk("t4_c8_pop", 32'(pop), 32'd0);
      cyc(); outs("t4_c9", 4'b0010, 1'b0, 10'h000, 2'd0);

      // 5: enable drops with ch1 and ch2 non-empty
      cyc(); enable = 1'b0; wr[1] = wr[1] + 16'd1; #1;
      outs("t5_c10", 4'b0000, 1'b1, 10'h101, 2'd1);
      cyc(); outs("t5_c11", 4'b0000, 1'b0, 10'h000, 2'd1);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_nonempty", 32'(empty_in[2:1]), 32'd0);

`ifdef ARB_CNT_EN
      // 6: ch3 alone granted 257 times -> cnt3 wraps to 1
      reset = 1'b1;
      cyc(); reset = 1'b0;
      chk("t6_rst_cnt", grant_cnt, 32'h0);
      drain_all();
      load(3, 257, 10'h000); enable = 1'b1;
      begin
         int pushes = 0;
         for (int c = 0; c < 700 && pushes < 257; c++) begin
            cyc();
            if (push_out) pushes++;
         end
         chk("t6_pushes", 32'(pushes), 32'd257);
      end
      cyc(); chk("t6_cnt", grant_cnt, 32'h0100_0000);
      reset = 1'b1;
      cyc(); reset = 1'b0;
      chk("t6_clear", grant_cnt, 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vc_pop_arbiter.md
Name: vc_pop_arbiter

Overview:
- Round-robin arbiter that drains four input virtual-channel FIFOs into a single downstream FIFO.
- Issues one-hot pops to the input FIFOs and muxes the selected FIFO's data onto a single push port.
- Throttles itself on the downstream almost_full flag.
- Sits between the per-channel FIFO bank and the shared output FIFO of the transaction datapath.

Parameters:
- data_width, 10, width of every FIFO word.
- NUM_CH, 4, number of input channels; fixed at 4 because grant encoding is 2 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = arbitration allowed; 0 = stop issuing new pops.
- empty_in  input  4  empty flag of input FIFO i, bit i.
- data_in0  input  data_width  read data of input FIFO 0.
- data_in1  input  data_width  read data of input FIFO 1.
- data_in2  input  data_width  read data of input FIFO 2.
- data_in3  input  data_width  read data of input FIFO 3.
- almost_full_out  input  1  downstream FIFO almost_full flag. The threshold leaves room for at least 2 more words.
- pop  output  4  one-hot pop to the input FIFOs.
- push_out  output  1  push to the downstream FIFO.
- data_out  output  data_width  word pushed downstream.
- grant  output  2  index of the channel whose word is on data_out.
- busy  output  1  high whenever the state is ACTIVE or STALL.
- grant_cnt  output  32  four 8-bit grant counters. Present only with ARB_CNT_EN.

Behaviour:
- Reset (synchronous, active-high, clk edge):
  - state=IDLE, rr_ptr=0.
  - pop=0, push_out=0, data_out=0, grant=0, busy=0.
  - Counters cleared.
  - Reset mid-operation drops any in-flight word: no push occurs on the cycle after reset.
- States:
  - IDLE: no pops. Go to ACTIVE when enable=1 and empty_in!=4'b1111 and almost_full_out=0.
  - ACTIVE: pop the first non-empty channel, searching from rr_ptr upward modulo 4.
    - almost_full_out=1 -> go to STALL.
    - enable=0 or all empty -> go to IDLE.
  - STALL: no pops. Go to ACTIVE when almost_full_out=0, enable=1 and any channel is non-empty; otherwise go to IDLE.
- Pop rules:
  - pop is combinational from state, rr_ptr, empty_in, enable and almost_full_out.
  - At most one pop bit is high. A pop is never issued to an empty channel.
  - pop is asserted only in ACTIVE, in a cycle where almost_full_out=0 and enable=1.
  - A pop fires in the same cycle the FSM leaves IDLE or STALL only if all pop conditions hold in that cycle.
- Round-robin pointer:
  - On a pop to channel k, rr_ptr <= (k+1) mod 4 at the next edge.
  - With no pop, rr_ptr holds.
- Data path (latency 1):
  - Input FIFOs present read data the cycle after pop.
  - sel_q and pop_q register the granted index and the pop event.
  - In cycle N+1: push_out=pop_q, data_out=data_in[sel_q], grant=sel_q.
  - When push_out=0, data_out is forced to 0 and grant holds its last value.
- In-flight word: a pop issued in the last cycle before STALL, IDLE or enable=0 still produces its push in the next cycle.
- Single-word FIFO: the input FIFO empty flag updates on the same edge that consumes the pop, so back-to-back pops to one channel are legal only if empty_in is still 0.
- Simultaneous events:
  - almost_full_out rising in the same cycle as a candidate pop suppresses that pop.
  - reset has priority over everything.

Optional Feature:
- Macro: ARB_CNT_EN
- Defined:
  - Per-channel 8-bit counters increment on each push_out for channel grant. They wrap 255 -> 0.
  - Counters are cleared by reset.
  - grant_cnt = {cnt3, cnt2, cnt1, cnt0}.
- Undefined: the counters and the grant_cnt port are absent. All other behaviour is identical.

Test Plan:
1. Reset held 2 cycles with all FIFOs non-empty -> pop=0, push_out=0, data_out=0 during reset and on the first cycle after reset.
2. Only ch0 holds 10'h090..10'h093, enable=1 -> four consecutive pop=4'b0001. push_out high cycles N+1..N+4 with data_out 10'h090..10'h093, grant=0. Then return to IDLE.
3. All four channels non-empty, rr_ptr=0 -> pop sequence 0001, 0010, 0100, 1000, 0001. grant on the following cycles is 0, 1, 2, 3, 0.
4. almost_full_out rises while ACTIVE -> pop=0 that cycle. The in-flight word is still pushed once. State=STALL, busy=1. almost_full_out falls -> pops resume from the saved rr_ptr.
5. enable dropped mid-stream with ch1 and ch2 non-empty -> no new pop. The last in-flight push completes. State=IDLE, busy=0.
6. ARB_CNT_EN, ch3 alone granted 256 times -> cnt3 wraps to 0 and cnt0..cnt2 stay 0. Reset then clears grant_cnt to 32'h0.
